// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, default parameters and the interrupt FSM encoding for the
// N-stage pipeline controller.
package pipeline_ctrl_pkg;

    // Stage indices of the classic five-stage pipe
    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;
    localparam int STAGE_WB  = 4;

    // Default parameter values
    localparam int DEF_NUM_STAGES     = 5;
    localparam int DEF_INTP_STAGE     = 3;
    localparam int DEF_MEM_STAGE      = 3;
    localparam int DEF_TIMEOUT_W      = 8;
    localparam int DEF_TIMEOUT_CYCLES = 200;

    // Interrupt-take FSM
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        REDIR = 2'd2
    } intp_state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the datapath and the pipeline controller. The datapath side
// (master) drives the per-stage requests; the controller (slave) returns the
// register enables/clears plus the FSM state for observation.
//
// Request semantics: hold_i[s] / redirect_i[s] are level requests that are
// only acted upon while stage s is valid; there is no ready back-pressure,
// the controller answers within the same cycle through stall_o/flush_o.
interface pipeline_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES
) ();

    logic                  fetch_ok_i;
    logic [NUM_STAGES-1:0] hold_i;
    logic [NUM_STAGES-1:0] redirect_i;
    logic                  intp_req_i;

    logic [NUM_STAGES-1:0] stage_valid_o;
    logic [NUM_STAGES-1:0] stall_o;
    logic [NUM_STAGES-1:0] flush_o;
    logic [NUM_STAGES-1:0] bubble_o;
    logic                  dont_fetch_o;
    logic                  intp_take_o;
    logic                  retire_o;
    logic                  mem_timeout_o;
    intp_state_e           fsm_state;

    modport master (
        output fetch_ok_i, hold_i, redirect_i, intp_req_i,
        input  stage_valid_o, stall_o, flush_o, bubble_o,
               dont_fetch_o, intp_take_o, retire_o, mem_timeout_o, fsm_state
    );

    modport slave (
        input  fetch_ok_i, hold_i, redirect_i, intp_req_i,
        output stage_valid_o, stall_o, flush_o, bubble_o,
               dont_fetch_o, intp_take_o, retire_o, mem_timeout_o, fsm_state
    );

endinterface

// File: rtl/pipeline_ctrl_timeout.sv
// Counts consecutive held cycles of the memory stage and pulses once every
// TIMEOUT_CYCLES held cycles. The count wraps back to zero on the pulse.
module pipeline_ctrl_timeout
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W      = DEF_TIMEOUT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    output logic pulse
);

    localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] count;

    assign pulse = hold & (count == LAST_COUNT);

    // Run-length counter of held cycles; cleared by a released hold or a pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!hold || pulse) begin
            count <= '0;
        end else begin
            count <= count + TIMEOUT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl_nstage.sv
// N-stage pipeline controller: per-stage valid tracking, stall/flush/bubble
// generation from hold and redirect requests, interrupt-take FSM at the commit
// stage and a memory-hold timeout watchdog.
module pipeline_ctrl_nstage
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_STAGES     = DEF_NUM_STAGES,
    parameter int INTP_STAGE     = DEF_INTP_STAGE,
    parameter int MEM_STAGE      = DEF_MEM_STAGE,
    parameter int TIMEOUT_W      = DEF_TIMEOUT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic             clk,
    input logic             rst_n,
    pipeline_ctrl_if.slave  bus
);

    localparam int LAST = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0] valid;
    logic [NUM_STAGES-1:0] valid_next;
    logic [NUM_STAGES-1:0] upstream;
    logic [NUM_STAGES-1:0] hold_eff;
    logic [NUM_STAGES-1:0] redir_eff;
    logic [NUM_STAGES-1:0] older_redir;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] flush;
    logic [NUM_STAGES-1:0] bubble;
    logic                  take;
    intp_state_e           state;
    logic                  unused_hold_wb;

    // WB always retires, so its hold request is dropped
    assign unused_hold_wb = bus.hold_i[LAST];
    assign hold_eff       = {1'b0, bus.hold_i[LAST-1:0] & valid[LAST-1:0]};
    assign redir_eff      = bus.redirect_i & valid & ~stall;
    assign upstream       = {valid[LAST-1:0], bus.fetch_ok_i};

    // The commit-stage instruction is taken only if nothing older redirects
    assign take = (state == DRAIN) & bus.intp_req_i & valid[INTP_STAGE] &
                  ~stall[INTP_STAGE] & ~older_redir[INTP_STAGE];

    genvar s;
    generate
        for (s = 0; s < NUM_STAGES; s++) begin : g_stage
            // Any hold at this stage or older freezes this stage
            assign stall[s] = |hold_eff[LAST:s];

            if (s == LAST) begin : g_oldest
                assign older_redir[s] = 1'b0;
            end else begin : g_younger
                assign older_redir[s] = |redir_eff[LAST:s+1];
            end

            if (s == 0) begin : g_first
                assign bubble[s] = 1'b0;
            end else begin : g_rest
                assign bubble[s] = stall[s-1] & ~stall[s];
            end

            if (s <= INTP_STAGE) begin : g_intp_flush
                assign flush[s] = older_redir[s] | take;
            end else begin : g_redir_flush
                assign flush[s] = older_redir[s];
            end

            // Priority: flush, then stall, then bubble, then normal advance
            assign valid_next[s] = flush[s]  ? 1'b0     :
                                   stall[s]  ? valid[s] :
                                   bubble[s] ? 1'b0     : upstream[s];
        end
    endgenerate

    // Per-stage valid register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            valid <= valid_next;
        end
    end

    // Interrupt FSM: wait for a takeable commit-stage instruction, then block
    // fetch for one cycle while the trap vector is loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.intp_req_i) state <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.intp_req_i) state <= IDLE;
                    else if (take)       state <= REDIR;
                end
                REDIR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    pipeline_ctrl_timeout #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (hold_eff[MEM_STAGE]),
        .pulse (bus.mem_timeout_o)
    );

    assign bus.stage_valid_o = valid;
    assign bus.stall_o       = stall;
    assign bus.flush_o       = flush;
    assign bus.bubble_o      = bubble;
    assign bus.dont_fetch_o  = (|flush) | stall[0] | (state == REDIR);
    assign bus.intp_take_o   = take;
    assign bus.retire_o      = valid[LAST];
    assign bus.fsm_state     = state;

endmodule
